// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU (add/sub/not/and/or/xor/slt/eq) plus iterative shift-add multiply.
// Latency: 1 cycle from accept to out_valid for logic/arith ops, WIDTH+1 cycles for MUL.
// Backpressure: one op in flight; in_ready only in IDLE, result and flags held until out_ready.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake; op, a, b captured on accept
//   op[3:0], a, b            operation select and WIDTH-bit operands
//   out_valid/out_ready      result handshake
//   result, cout, overflow,  registered result and flags, stable while out_valid=1
//   zero, illegal
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_NOT = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SLT = 4'b0110;
  localparam logic [3:0] OP_EQ  = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  // Everything presented on the output side travels as one registered bundle.
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             illegal;
  } res_t;

  state_t             state;
  logic               in_ready_q;
  logic               out_valid_q;
  res_t               res_q;

  // Multiply datapath: accumulator and shifted multiplicand are double width
  // so the high half is available for the overflow flag.
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_nxt;
  res_t               mul_res;

  // Single-cycle ALU, evaluated straight off the inputs and latched on accept.
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     dif_w;
  logic               add_ovf;
  logic               sub_ovf;
  logic               slt_bit;
  res_t               alu_res;

  always_comb begin
    sum_w   = {1'b0, a} + {1'b0, b};
    // Two's-complement subtract so the carry out means "no borrow".
    dif_w   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
    sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);
    // Signed a<b: sign of the difference, corrected when the subtract overflowed.
    slt_bit = dif_w[WIDTH-1] ^ sub_ovf;

    alu_res = '0;
    case (op)
      OP_ADD: begin
        alu_res.result   = sum_w[WIDTH-1:0];
        alu_res.cout     = sum_w[WIDTH];
        alu_res.overflow = add_ovf;
      end
      OP_SUB: begin
        alu_res.result   = dif_w[WIDTH-1:0];
        alu_res.cout     = dif_w[WIDTH];
        alu_res.overflow = sub_ovf;
      end
      OP_NOT: alu_res.result = ~a;
      OP_AND: alu_res.result = a & b;
      OP_OR:  alu_res.result = a | b;
      OP_XOR: alu_res.result = a ^ b;
      OP_SLT: begin
        alu_res.result   = {{(WIDTH-1){1'b0}}, slt_bit};
        alu_res.overflow = sub_ovf;
      end
      OP_EQ:  alu_res.result = {{(WIDTH-1){1'b0}}, (dif_w[WIDTH-1:0] == '0)};
      OP_MUL: ; // handled by the iterative datapath, never latched from here
      default: alu_res.illegal = 1'b1;
    endcase
    alu_res.zero = (alu_res.result == '0);
  end

  always_comb begin
    acc_nxt          = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_res          = '0;
    mul_res.result   = acc_nxt[WIDTH-1:0];
    mul_res.overflow = |acc_nxt[2*WIDTH-1:WIDTH];
    mul_res.zero     = (acc_nxt[WIDTH-1:0] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (op == OP_MUL) begin
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, a};
              mplier_q <= b;
              cnt_q    <= '0;
              state    <= S_MUL;
            end else begin
              res_q       <= alu_res;
              out_valid_q <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_MUL: begin
          // One multiplier bit per cycle, LSB first.
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            res_q       <= mul_res;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q.result;
  assign cout      = res_q.cout;
  assign overflow  = res_q.overflow;
  assign zero      = res_q.zero;
  assign illegal   = res_q.illegal;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  // WIDTH=8 instance
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  result;
  logic        cout;
  logic        overflow;
  logic        zero;
  logic        illegal;

  // WIDTH=16 instance
  logic        w_in_valid;
  logic        w_in_ready;
  logic [3:0]  w_op;
  logic [15:0] w_a;
  logic [15:0] w_b;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [15:0] w_result;
  logic        w_cout;
  logic        w_overflow;
  logic        w_zero;
  logic        w_illegal;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .overflow(overflow), .zero(zero), .illegal(illegal)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op), .a(w_a), .b(w_b),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .result(w_result),
    .cout(w_cout), .overflow(w_overflow), .zero(w_zero), .illegal(w_illegal)
  );

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
    logic       il;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string n, input logic [3:0] o, input logic [7:0] va,
                         input logic [7:0] vb, input logic [7:0] r, input logic c,
                         input logic v, input logic z, input logic il);
    vec_t t;
    t.name = n; t.op = o; t.a = va; t.b = vb; t.res = r;
    t.c = c; t.v = v; t.z = z; t.il = il;
    vq.push_back(t);
  endtask

  // Issue one op on the 8-bit instance and wait (bounded) for out_valid.
  // lat counts cycles from the accepting edge to the first cycle with out_valid.
  task automatic run8(input logic [3:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                      output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick;
      guard++;
    end
    in_valid = 1'b1;
    op = t_op;
    a = t_a;
    b = t_b;
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick;
      lat++;
    end
  endtask

  task automatic consume8;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  initial begin
    int         lat;
    logic [7:0] held_res;
    logic [3:0] held_flags;

    rst = 1'b1;
    in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_op = '0; w_a = '0; w_b = '0; w_out_ready = 1'b0;

    //        name        op       a      b      res    c     v     z     il
    add_vec("add_7f_01", 4'b0000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec("add_ff_01", 4'b0000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    add_vec("sub_05_05", 4'b0001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    add_vec("sub_03_05", 4'b0001, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec("sub_80_01", 4'b0001, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec("not_0f",    4'b0010, 8'h0F, 8'h55, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec("and",       4'b0011, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec("or",        4'b0100, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec("xor_same",  4'b0101, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    add_vec("slt_80_01", 4'b0110, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec("slt_01_80", 4'b0110, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec("slt_03_05", 4'b0110, 8'h03, 8'h05, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec("eq_05_05",  4'b0111, 8'h05, 8'h05, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec("eq_05_06",  4'b0111, 8'h05, 8'h06, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    add_vec("mul_0f_11", 4'b1000, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec("mul_10_10", 4'b1000, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec("mul_ff_ff", 4'b1000, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec("mul_00_37", 4'b1000, 8'h00, 8'h37, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    add_vec("ill_1010",  4'b1010, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    add_vec("ill_1111",  4'b1111, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    tick;
    tick;
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {cout, overflow, zero, illegal}, 0);
    chk("rst16_in_ready", w_in_ready, 1);
    chk("rst16_out_valid", w_out_valid, 0);

    // Table-driven sweep
    foreach (vq[i]) begin
      run8(vq[i].op, vq[i].a, vq[i].b, lat);
      chk({vq[i].name, "_lat"}, lat, (vq[i].op == 4'b1000) ? 9 : 1);
      chk({vq[i].name, "_result"}, result, vq[i].res);
      chk({vq[i].name, "_cout"}, cout, vq[i].c);
      chk({vq[i].name, "_overflow"}, overflow, vq[i].v);
      chk({vq[i].name, "_zero"}, zero, vq[i].z);
      chk({vq[i].name, "_illegal"}, illegal, vq[i].il);
      consume8;
      chk({vq[i].name, "_in_ready_after"}, in_ready, 1);
      chk({vq[i].name, "_out_valid_after"}, out_valid, 0);
    end

    // Backpressure: hold the ADD result for 5 cycles while a new op is offered
    run8(4'b0000, 8'h7F, 8'h01, lat);
    held_res = 8'h80;
    held_flags = 4'b0100; // cout=0 overflow=1 zero=0 illegal=0
    in_valid = 1'b1; op = 4'b0001; a = 8'h10; b = 8'h20;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", result, held_res);
      chk("bp_flags", {cout, overflow, zero, illegal}, held_flags);
    end
    in_valid = 1'b0;
    consume8;
    chk("bp_release_in_ready", in_ready, 1);
    tick;
    tick;
    chk("bp_ignored_no_output", out_valid, 0);

    // Reset during MUL iteration 4
    in_valid = 1'b1; op = 4'b1000; a = 8'h0F; b = 8'h11;
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick;
    chk("mulabort_busy", in_ready, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mulabort_out_valid", out_valid, 0);
    chk("mulabort_in_ready", in_ready, 1);
    chk("mulabort_result", result, 0);
    for (int k = 0; k < 10; k++) tick;
    chk("mulabort_never_presented", out_valid, 0);
    run8(4'b0000, 8'h02, 8'h03, lat);
    chk("post_abort_add_lat", lat, 1);
    chk("post_abort_add_result", result, 8'h05);
    consume8;

    // Back-to-back ops: accept, result, consume, accept again two cycles later
    run8(4'b0011, 8'hFF, 8'h0F, lat);
    out_ready = 1'b1;
    in_valid = 1'b1; op = 4'b0100; a = 8'h01; b = 8'h02;
    tick;
    out_ready = 1'b0;
    chk("b2b_in_ready", in_ready, 1);
    tick;
    in_valid = 1'b0;
    chk("b2b_second_valid", out_valid, 1);
    chk("b2b_second_result", result, 8'h03);
    consume8;

    // WIDTH=16: ADD 0x7FFF+1
    w_in_valid = 1'b1; w_op = 4'b0000; w_a = 16'h7FFF; w_b = 16'h0001;
    tick;
    w_in_valid = 1'b0;
    chk("w16_add_valid", w_out_valid, 1);
    chk("w16_add_result", w_result, 16'h8000);
    chk("w16_add_overflow", w_overflow, 1);
    chk("w16_add_cout", w_cout, 0);
    chk("w16_add_zero", w_zero, 0);
    w_out_ready = 1'b1;
    tick;
    w_out_ready = 1'b0;
    chk("w16_in_ready_after", w_in_ready, 1);

    // WIDTH=16: MUL 0x00FF*0x0101 = 0xFFFF, WIDTH+1 = 17 cycles
    w_in_valid = 1'b1; w_op = 4'b1000; w_a = 16'h00FF; w_b = 16'h0101;
    tick;
    w_in_valid = 1'b0;
    lat = 1;
    while (!w_out_valid && lat < 60) begin
      tick;
      lat++;
    end
    chk("w16_mul_lat", lat, 17);
    chk("w16_mul_result", w_result, 16'hFFFF);
    chk("w16_mul_overflow", w_overflow, 0);
    w_out_ready = 1'b1;
    tick;
    w_out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
